ones_run_serializer: RTL and testbench
======================================

Name: ones_run_serializer

Overview:
- Serial transmitter for the consecutive-ones detector interface.
- Accepts parallel words through a valid/ready handshake and shifts them out LSB-first on a single-bit stream `c`.
- Drives `exp_d`, a predicted Mealy detector output for the overlapping run-of-RUN_LEN-ones rule, so a downstream detector can be checked bit-for-bit.
- Keeps a saturating count of predicted detections.

Parameters:
- WIDTH, 8, bits per loaded word (>=2).
- RUN_LEN, 3, consecutive 1s required for a detection (>=2).
- CNT_W, 16, width of the detection counter.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  word to serialize, bit 0 sent first.
- clr_count  input  1  synchronous clear of det_count.
- c  output  1  serial bit; 0 whenever c_valid=0.
- c_valid  output  1  c carries a data bit this cycle.
- exp_d  output  1  predicted detector output for the current bit (Mealy).
- busy  output  1  word in flight (state SHIFT).
- det_count  output  CNT_W  saturating count of exp_d pulses.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE; shift register, bit index and run counter =0.
  - c=0, c_valid=0, exp_d=0, busy=0, det_count=0, load_ready=1.
  - Reset mid-word abandons the word; no further bits of it are sent.
- Registers: shift register SR[WIDTH-1:0], bit index IDX (0..WIDTH-1), run counter RUN saturating at RUN_LEN-1, det_count.
- FSM states: IDLE, SHIFT.
  - IDLE: load_ready=1, c_valid=0, c=0. If load_valid, go to SHIFT: SR<=load_data, IDX<=0.
  - SHIFT: c_valid=1, c=SR[0], busy=1. Each cycle: SR shifts right one bit, IDX increments.
  - SHIFT, at IDX=WIDTH-1 (last bit): load_ready=1.
    - If load_valid is high, SR reloads, IDX<=0 and state stays SHIFT. The next word follows with no gap.
    - If load_valid is low, go to IDLE.
  - SHIFT, at IDX<WIDTH-1: load_ready=0; load_valid is ignored.
- Latency: a handshake at edge N puts bit0 on c in cycle N+1. Bit k appears in cycle N+1+k.
- Run tracking, per edge:
  - If c_valid && c: RUN<=min(RUN+1, RUN_LEN-1).
  - Otherwise RUN<=0. Idle cycles count as c=0, so a gap breaks a run.
- exp_d = c_valid && c && (RUN==RUN_LEN-1). This is combinational from the registered state and current c, with no added latency. Overlapping: one pulse per 1 bit once the run length reaches RUN_LEN.
- det_count, per edge:
  - If clr_count: det_count<=0. Clear wins over a simultaneous exp_d.
  - Else if exp_d and det_count != all-ones: det_count increments.
  - At all-ones it holds (saturates, no wrap).
- Runs continue across back-to-back word boundaries.
- load_valid is sampled only when load_ready=1. load_data may change freely otherwise.

Test Plan (WIDTH=8, RUN_LEN=3 unless stated):
1. Single load 0xFF, then idle:
   - c=1 for 8 cycles starting the cycle after the handshake.
   - exp_d high on bits 2..7 (6 pulses); det_count=6.
   - Then c_valid=0, load_ready=1.
2. Load 0x57 (sent as 1,1,1,0,1,0,1,0):
   - exp_d pulses once, on bit 2; det_count=1.
   - busy high for exactly 8 cycles.
3. Back-to-back loads:
   - 0xC0 then 0x03, with load_valid held through the last bit: no gap; stream ...0,1,1,1,1,0...; exp_d on bits 0 and 1 of the second word; det_count=2.
   - Repeat with one idle cycle between the words: det_count=0.
4. clr_count asserted in the same cycle as an exp_d pulse during 0xFF: det_count=0 after that edge, then increments normally on the remaining pulses.
5. reset driven low after bit 3 of 0xFF:
   - Outputs go to reset values immediately (c=0, c_valid=0, busy=0, det_count=0).
   - After release, a new 0x07 load yields exp_d on bit 2 only.
6. CNT_W=4: three back-to-back 0xFF loads give 22 predicted pulses; det_count saturates at 15 and holds.

Source files
------------

// File: rtl/ones_run_serializer.sv
// LSB-first word serializer with a predicted Mealy run-of-ones detector output
// and a saturating count of predicted detections.
module ones_run_serializer #(
    parameter int WIDTH   = 8,
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clr_count,
    output logic             c,
    output logic             c_valid,
    output logic             exp_d,
    output logic             busy,
    output logic [CNT_W-1:0] det_count
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RUN_W = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] sr_r, sr_nxt_s;
    logic [IDX_W-1:0] idx_r, idx_nxt_s;
    logic [RUN_W-1:0] run_r, run_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             shifting_s, last_bit_s, bit_s, exp_d_s;

    // Decode of the observable stream from the registered state.
    always_comb begin
        shifting_s = (state_r == SHIFT);
        last_bit_s = shifting_s && (idx_r == IDX_LAST);
        bit_s      = shifting_s && sr_r[0];
        exp_d_s    = bit_s && (run_r == RUN_MAX);
    end

    // Next-state logic: load, shift, and zero-gap reload on the last bit.
    always_comb begin
        state_nxt_s = state_r;
        sr_nxt_s    = sr_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (load_valid) begin
                    state_nxt_s = SHIFT;
                    sr_nxt_s    = load_data;
                    idx_nxt_s   = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (idx_r == IDX_LAST) begin
                    if (load_valid) begin
                        state_nxt_s = SHIFT;
                        sr_nxt_s    = load_data;
                        idx_nxt_s   = {IDX_W{1'b0}};
                    end else begin
                        state_nxt_s = IDLE;
                        sr_nxt_s    = {WIDTH{1'b0}};
                        idx_nxt_s   = {IDX_W{1'b0}};
                    end
                end else begin
                    sr_nxt_s  = {1'b0, sr_r[WIDTH-1:1]};
                    idx_nxt_s = idx_r + IDX_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                sr_nxt_s    = {WIDTH{1'b0}};
                idx_nxt_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Run tracking (idle cycles break a run) and the saturating detection count.
    always_comb begin
        run_nxt_s = {RUN_W{1'b0}};
        cnt_nxt_s = cnt_r;
        if (bit_s) begin
            if (run_r == RUN_MAX) begin
                run_nxt_s = run_r;
            end else begin
                run_nxt_s = run_r + RUN_W'(1);
            end
        end else begin
            run_nxt_s = {RUN_W{1'b0}};
        end
        if (clr_count) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (exp_d_s && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            sr_r    <= {WIDTH{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            run_r   <= {RUN_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            sr_r    <= sr_nxt_s;
            idx_r   <= idx_nxt_s;
            run_r   <= run_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign load_ready = !shifting_s || last_bit_s;
    assign c          = bit_s;
    assign c_valid    = shifting_s;
    assign busy       = shifting_s;
    assign exp_d      = exp_d_s;
    assign det_count  = cnt_r;

endmodule

// File: tb/tb_ones_run_serializer.sv
// Scoreboard bench: driver pushes each word's expected bits and detector
// predictions into a queue; a negedge monitor pops and compares them.
module tb_ones_run_serializer;

    localparam int W = 8;
    localparam int R = 3;

    logic         clk = 1'b0;
    logic         reset, load_valid, clr_count;
    logic [W-1:0] load_data;
    logic         load_ready, c, c_valid, exp_d, busy;
    logic [15:0]  det_count;
    logic         load_ready2, c2, c_valid2, exp_d2, busy2;
    logic [3:0]   det_count2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]  q[$];
    int          model_ones = 0;
    int          m16 = 0;
    int          m4  = 0;
    logic        mon_en = 1'b0;
    logic        clr_en = 1'b0;
    logic [1:0]  ent;
    logic        ee;

    ones_run_serializer #(.WIDTH(W), .RUN_LEN(R), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .clr_count(clr_count), .c(c), .c_valid(c_valid),
        .exp_d(exp_d), .busy(busy), .det_count(det_count)
    );

    ones_run_serializer #(.WIDTH(W), .RUN_LEN(R), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready2),
        .load_data(load_data), .clr_count(clr_count), .c(c2), .c_valid(c_valid2),
        .exp_d(exp_d2), .busy(busy2), .det_count(det_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    endtask

    // Idle cycles: a gap in the stream breaks any run of ones.
    task automatic idle(input int n);
        if (n > 0) model_ones = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one word; returns 1 time unit after the handshake edge.
    task automatic handshake(input logic [W-1:0] w);
        load_valid = 1'b1;
        load_data  = w;
        #3;
        check("load_ready_at_hs", {31'd0, load_ready}, 32'd1);
        check("load_ready4_at_hs", {31'd0, load_ready2}, 32'd1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = W'($urandom);
        for (int k = 0; k < W; k++) begin
            model_ones = w[k] ? model_ones + 1 : 0;
            q.push_back({w[k], (model_ones >= R) ? 1'b1 : 1'b0});
        end
    endtask

    // Ride out bits 0..6 with junk on the load inputs; returns inside the last-bit cycle.
    task automatic finish_word();
        for (int i = 0; i < W - 1; i++) begin
            load_valid = 1'($urandom);
            load_data  = W'($urandom);
            #3;
            check("load_ready_mid", {31'd0, load_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] w);
        handshake(w);
        finish_word();
    endtask

    // Monitor: compare the stream against the scoreboard, track predicted counts.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            ee = 1'b0;
            if (c_valid) begin
                if (q.size() == 0) begin
                    check("spurious_c_valid", {31'd0, c_valid}, 32'd0);
                end else begin
                    ent = q.pop_front();
                    ee  = ent[0];
                    check("stream", {28'd0, c, c_valid, exp_d, busy}, {28'd0, ent[1], 1'b1, ent[0], 1'b1});
                    check("stream4", {28'd0, c2, c_valid2, exp_d2, busy2}, {28'd0, ent[1], 1'b1, ent[0], 1'b1});
                end
            end else begin
                check("idle_out", {28'd0, c, c_valid, exp_d, busy}, 32'd0);
                check("idle_out4", {28'd0, c2, c_valid2, exp_d2, busy2}, 32'd0);
            end
            check("det_count", {16'd0, det_count}, 32'(m16));
            check("det_count4", {28'd0, det_count2}, 32'(m4));
            if (clr_count) begin
                m16 = 0;
                m4  = 0;
            end else if (ee) begin
                if (m16 < 65535) m16 = m16 + 1;
                if (m4 < 15) m4 = m4 + 1;
            end
        end
    end

    // Random synchronous clears, only during the random phase.
    always @(posedge clk) begin
        #1;
        clr_count = clr_en && ($urandom_range(0, 15) == 0);
    end

    initial begin
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        clr_count  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {27'd0, c, c_valid, exp_d, busy, load_ready}, 32'd1);
        check("rst_count", {16'd0, det_count}, 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        idle(2);

        send(8'hFF);  idle(3);
        send(8'h57);  idle(3);
        send(8'hC0);  send(8'h03);  idle(3);
        send(8'hC0);  idle(1);  send(8'h03);  idle(3);

        // Abandon 0xFF mid-word with an asynchronous reset.
        handshake(8'hFF);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        check("midword_rst_out", {27'd0, c, c_valid, exp_d, busy, load_ready}, 32'd1);
        check("midword_rst_cnt", {16'd0, det_count}, 32'd0);
        q.delete();
        model_ones = 0;
        m16 = 0;
        m4  = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);
        send(8'h07);  idle(3);

        // Saturation of the narrow counter: 22 pulses into a 4-bit count.
        send(8'hFF);  send(8'hFF);  send(8'hFF);  idle(3);

        clr_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            send(W'($urandom | $urandom));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(4);
        clr_en = 1'b0;
        idle(4);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
